// File: rtl/huffman_bit_packer_pkg.sv
// Shared widths and FSM encoding for the Huffman bit packer.
package huffman_bit_packer_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_CNT_W  = 32;
  localparam int ACC_W      = 2 * DEF_DATA_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/huffman_bit_packer_shift_insert.sv
// Masks a right-justified code to len_eff bits and ORs it into acc at bit offset fill.
// Purely combinational; bits of acc at and above fill are zero by construction.
module packer_shift_insert
  import huffman_bit_packer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int AW     = 2 * DATA_W,
  parameter int FW     = $clog2(AW)
) (
  input  logic [AW-1:0]     acc,
  input  logic [DATA_W-1:0] code,
  input  logic [LEN_W-1:0]  len_eff,
  input  logic [FW-1:0]     fill,
  output logic [AW-1:0]     acc_ins
);
  logic [AW-1:0] mask;
  logic [AW-1:0] code_ext;

  assign mask     = ~({AW{1'b1}} << len_eff);
  assign code_ext = {{(AW - DATA_W){1'b0}}, code} & mask;
  assign acc_ins  = acc | (code_ext << fill);
endmodule

// File: rtl/huffman_bit_packer.sv
// Packs variable-length LSB-first codes into dense DATA_W-bit words; flush emits a zero-padded tail.
// Words appear the cycle after the completing code; stall is register-only, never from out_ready.
module huffman_bit_packer
  import huffman_bit_packer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] code_in,
  input  logic [LEN_W-1:0]  code_len,
  input  logic              code_valid,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic [LEN_W-1:0]  word_bits,
  output logic              word_last,
  input  logic              out_ready,
  output logic              flush_done,
  output logic [CNT_W-1:0]  bit_count
);
  localparam int AW = 2 * DATA_W;
  localparam int FW = $clog2(AW);

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d, acc_ins;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [LEN_W-1:0] len_eff;
  logic             full, accept, pop;

  assign len_eff   = (code_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : code_len;
  assign full      = (fill_q >= FW'(DATA_W));
  assign bit_count = bit_count_q;

  packer_shift_insert #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .AW     (AW),
    .FW     (FW)
  ) u_shift_insert (
    .acc     (acc_q),
    .code    (code_in),
    .len_eff (len_eff),
    .fill    (fill_q),
    .acc_ins (acc_ins)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      acc_q       <= '0;
      fill_q      <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      bit_count_q <= bit_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    bit_count_d = bit_count_q;
    word_valid  = 1'b0;
    word_out    = '0;
    word_bits   = '0;
    word_last   = 1'b0;
    flush_done  = 1'b0;
    stall       = full || (state_q != RUN);
    accept      = code_valid && !stall;

    case (state_q)
      RUN: begin
        if (full) begin
          word_valid = 1'b1;
          word_out   = acc_q[DATA_W-1:0];
          word_bits  = LEN_W'(DATA_W);
        end
        if (flush && !stall) state_d = FLUSH;
      end
      FLUSH: begin
        if (full) begin
          word_valid = 1'b1;
          word_out   = acc_q[DATA_W-1:0];
          word_bits  = LEN_W'(DATA_W);
        end else if (fill_q != '0) begin
          // Tail word: bits above fill are already zero in acc.
          word_valid = 1'b1;
          word_out   = acc_q[DATA_W-1:0];
          word_bits  = LEN_W'(fill_q);
          word_last  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase

    pop = word_valid && out_ready;

    if (accept) begin
      acc_d       = acc_ins;
      fill_d      = fill_q + FW'(len_eff);
      bit_count_d = bit_count_q + CNT_W'(len_eff);
    end else if (pop) begin
      if (word_last) begin
        acc_d  = '0;
        fill_d = '0;
      end else begin
        acc_d  = acc_q >> DATA_W;
        fill_d = fill_q - FW'(DATA_W);
      end
    end
  end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed self-checking bench for huffman_bit_packer with hand-computed expectations.
module tb_huffman_bit_packer;
  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] code_in;
  logic [7:0]  code_len;
  logic        code_valid;
  logic        flush;
  logic        stall;
  logic [63:0] word_out;
  logic        word_valid;
  logic [7:0]  word_bits;
  logic        word_last;
  logic        out_ready;
  logic        flush_done;
  logic [31:0] bit_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  huffman_bit_packer dut (
    .clock      (clock),
    .reset      (reset),
    .code_in    (code_in),
    .code_len   (code_len),
    .code_valid (code_valid),
    .flush      (flush),
    .stall      (stall),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_bits  (word_bits),
    .word_last  (word_last),
    .out_ready  (out_ready),
    .flush_done (flush_done),
    .bit_count  (bit_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] c, input logic [7:0] l);
    code_in    = c;
    code_len   = l;
    code_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b0; code_in = '0; code_len = '0; code_valid = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_word_valid", word_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_word_bits", word_bits, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_bit_count", bit_count, 0);
    reset = 1'b1;

    // Eight byte codes fill exactly one word.
    for (int i = 0; i < 8; i++) begin
      chk("t1_stall_pre", stall, 0);
      send(64'(i + 1), 8'd8);
      tick();
    end
    code_valid = 1'b0;
    chk("t1_valid", word_valid, 1);
    chk("t1_word", word_out, 64'h0807060504030201);
    chk("t1_bits", word_bits, 64);
    chk("t1_last", word_last, 0);
    chk("t1_stall", stall, 1);
    chk("t1_count", bit_count, 64);
    tick();
    chk("t1_stall_after", stall, 0);
    chk("t1_valid_after", word_valid, 0);

    // 60 + 10 bits: one full word, 6-bit tail on flush.
    send(64'h0FFF_FFFF_FFFF_FFFF, 8'd60); tick();
    send(64'h3FF, 8'd10); tick();
    code_valid = 1'b0;
    chk("t2_word", word_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_stall", stall, 1);
    tick();
    chk("t2_stall_popped", stall, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_tail_valid", word_valid, 1);
    chk("t2_tail_word", word_out, 64'h3F);
    chk("t2_tail_bits", word_bits, 6);
    chk("t2_tail_last", word_last, 1);
    chk("t2_tail_stall", stall, 1);
    tick();
    chk("t2_after_tail_valid", word_valid, 0);
    chk("t2_after_tail_done", flush_done, 0);
    tick();
    chk("t2_done", flush_done, 1);
    chk("t2_done_stall", stall, 1);
    tick();
    chk("t2_done_clear", flush_done, 0);
    chk("t2_run_stall", stall, 0);
    chk("t2_count", bit_count, 134);

    // Backpressure holds the word and the pending code.
    out_ready = 1'b0;
    send(64'hAAAA_5555_AAAA_5555, 8'd64); tick();
    send(64'h5A, 8'd8);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_stall", stall, 1);
      chk("t3_hold_valid", word_valid, 1);
      chk("t3_hold_word", word_out, 64'hAAAA_5555_AAAA_5555);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_pop_stall", stall, 0);
    chk("t3_pop_valid", word_valid, 0);
    chk("t3_count_pre", bit_count, 198);
    tick();
    code_valid = 1'b0;
    chk("t3_count_post", bit_count, 206);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_tail_word", word_out, 64'h5A);
    chk("t3_tail_bits", word_bits, 8);
    chk("t3_tail_last", word_last, 1);
    tick(); tick();
    chk("t3_done", flush_done, 1);
    tick();

    // Flush coinciding with the code that completes 128 bits: no tail word.
    send(64'h1111_2222_3333_4444, 8'd64); tick();
    code_valid = 1'b0;
    chk("t4_w0", word_out, 64'h1111_2222_3333_4444);
    chk("t4_w0_last", word_last, 0);
    tick();
    send(64'h5555_6666_7777_8888, 8'd64); flush = 1'b1;
    tick();
    code_valid = 1'b0; flush = 1'b0;
    chk("t4_w1_valid", word_valid, 1);
    chk("t4_w1", word_out, 64'h5555_6666_7777_8888);
    chk("t4_w1_last", word_last, 0);
    chk("t4_w1_bits", word_bits, 64);
    tick();
    chk("t4_no_tail", word_valid, 0);
    chk("t4_not_done_yet", flush_done, 0);
    tick();
    chk("t4_done", flush_done, 1);
    tick();
    chk("t4_count", bit_count, 334);

    // Zero-length no-op, clamped length, masking of bits above code_len.
    reset = 1'b0; tick(); reset = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'd0); tick();
    chk("t5_len0_stall", stall, 0);
    chk("t5_len0_valid", word_valid, 0);
    chk("t5_len0_count", bit_count, 0);
    send(64'h0123_4567_89AB_CDEF, 8'd70); tick();
    code_valid = 1'b0;
    chk("t5_clamp_valid", word_valid, 1);
    chk("t5_clamp_word", word_out, 64'h0123_4567_89AB_CDEF);
    chk("t5_clamp_count", bit_count, 64);
    tick();
    chk("t5_clamp_fill_empty", word_valid, 0);
    send(64'hFFFF_FFFF_FFFF_FFF5, 8'd4); flush = 1'b1; tick();
    code_valid = 1'b0; flush = 1'b0;
    chk("t5_mask_word", word_out, 64'h5);
    chk("t5_mask_bits", word_bits, 4);
    tick(); tick(); tick();

    // Reset in the middle of a flush with 37 bits buffered.
    send(64'h1F_FFFF_FFFF, 8'd37); flush = 1'b1; out_ready = 1'b0; tick();
    code_valid = 1'b0; flush = 1'b0;
    chk("t6_tail_bits", word_bits, 37);
    chk("t6_tail_valid", word_valid, 1);
    reset = 1'b0; tick(); reset = 1'b1; out_ready = 1'b1;
    chk("t6_valid", word_valid, 0);
    chk("t6_stall", stall, 0);
    chk("t6_count", bit_count, 0);
    chk("t6_word", word_out, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_done", flush_done, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
